// File: rtl/ppm_frame_receiver.sv
// Receive-side framer for the pulse-position optical link.
// Locks onto a fixed-period preamble, demodulates pulse-position symbols into an
// N_PKT-bit word and holds it in a one-entry buffer with an avail/read handshake.
// Framing, timing, stuck-line and overrun faults produce a one-cycle error strobe.
module ppm_frame_receiver #(
    parameter int unsigned PULSE_CT = 7500,  // nominal pulse high time, cycles
    parameter int unsigned N_MOD    = 2,     // bits per symbol
    parameter int unsigned L        = 15000, // slot length, cycles
    parameter int unsigned N_PKT    = 8,     // payload bits, multiple of N_MOD
    parameter int unsigned PRE_CT   = 4,     // preamble rises per frame, >= 2
    parameter int unsigned DELTA    = 4000   // timing tolerance, < L/2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pulse,
    input  logic             read,
    output logic [N_PKT-1:0] data,
    output logic             avail,
    output logic             error
);

    localparam int unsigned N_POS = 2 ** N_MOD;
    localparam int unsigned N_SYM = N_PKT / N_MOD;
    localparam int unsigned CNT_W = $clog2((2 ** (N_MOD + 1) - 1) * L + DELTA + 2);
    localparam int unsigned HI_W  = $clog2(PULSE_CT + DELTA + 2);
    localparam int unsigned PRE_W = $clog2(PRE_CT + 1);
    localparam int unsigned SYM_W = $clog2(N_SYM + 1);
    // Interval multiples run from 1 to 2^(N_MOD+1)-1 slots.
    localparam int unsigned K_W   = N_MOD + 1;

    // cnt_q stops one below all-ones so elapsed (cnt_q + 1) never wraps.
    localparam logic [CNT_W-1:0] CNT_SAT   = {CNT_W{1'b1}} - CNT_W'(1);
    localparam logic [CNT_W-1:0] L_C       = CNT_W'(L);
    localparam logic [CNT_W-1:0] DELTA_C   = CNT_W'(DELTA);
    localparam logic [CNT_W-1:0] PRE_LO    = CNT_W'(L - DELTA);
    localparam logic [CNT_W-1:0] PRE_HI    = CNT_W'(L + DELTA);
    localparam logic [HI_W-1:0]  STUCK_LIM = HI_W'(PULSE_CT + DELTA);
    localparam logic [HI_W-1:0]  HI_SAT    = HI_W'(PULSE_CT + DELTA + 1);
    localparam logic [PRE_W-1:0] PRE_LAST  = PRE_W'(PRE_CT);
    localparam logic [SYM_W-1:0] SYM_LAST  = SYM_W'(N_SYM);
    localparam logic [K_W-1:0]   K_BASE    = K_W'(N_POS);
    localparam logic [K_W-1:0]   K_TOP     = K_W'(2 * N_POS - 1);

    typedef enum logic [1:0] {
        StIdle,
        StPre,
        StSym
    } state_e;

    state_e             state_q, state_d;
    logic               pulse_q, pulse_prev_q;
    logic [HI_W-1:0]    hi_cnt_q, hi_cnt_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [PRE_W-1:0]   pre_cnt_q, pre_cnt_d;
    logic [SYM_W-1:0]   sym_idx_q, sym_idx_d;
    logic [N_MOD-1:0]   v_prev_q, v_prev_d;
    logic [N_PKT-1:0]   shift_q, shift_d;
    logic [N_PKT-1:0]   data_q, data_d;
    logic               avail_q, avail_d;
    logic               error_q, error_d;

    logic               rise;
    logic               stuck;
    logic [CNT_W-1:0]   elapsed;
    logic [CNT_W-1:0]   sym_top;
    logic               sym_hit;
    logic [N_MOD-1:0]   sym_w;
    logic [N_PKT-1:0]   shift_next;
    logic [K_W-1:0]     k;
    logic [CNT_W-1:0]   nom;

    // elapsed equals the detection-to-detection interval on the cycle a rise is seen.
    assign rise       = pulse_q & ~pulse_prev_q;
    assign stuck      = hi_cnt_q > STUCK_LIM;
    assign elapsed    = cnt_q + CNT_W'(1);
    assign sym_top    = CNT_W'(K_TOP - K_W'(v_prev_q)) * L_C + DELTA_C;
    assign shift_next = N_PKT'({shift_q, sym_w});

    // Run-length of consecutive high samples, tracked alongside the pulse sample.
    always_comb begin
        hi_cnt_d = '0;
        if (pulse) begin
            hi_cnt_d = (hi_cnt_q == HI_SAT) ? hi_cnt_q : hi_cnt_q + HI_W'(1);
        end
    end

    // Compare elapsed against every candidate symbol interval in parallel.
    always_comb begin
        sym_hit = 1'b0;
        sym_w   = '0;
        k       = '0;
        nom     = '0;
        for (int w = 0; w < N_POS; w++) begin
            k   = K_BASE - K_W'(v_prev_q) + K_W'(w);
            nom = CNT_W'(k) * L_C;
            // DELTA < L/2 keeps the windows disjoint, so at most one hits.
            if ((elapsed >= nom - DELTA_C) && (elapsed <= nom + DELTA_C)) begin
                sym_hit = 1'b1;
                sym_w   = N_MOD'(w);
            end
        end
    end

    // Framing FSM, interval counter, output buffer and handshake next-state.
    always_comb begin
        state_d   = state_q;
        cnt_d     = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + CNT_W'(1);
        pre_cnt_d = pre_cnt_q;
        sym_idx_d = sym_idx_q;
        v_prev_d  = v_prev_q;
        shift_d   = shift_q;
        data_d    = data_q;
        avail_d   = avail_q;
        error_d   = 1'b0;

        if (avail_q && read) begin
            avail_d = 1'b0;
        end

        case (state_q)
            StIdle: begin
                if (rise) begin
                    state_d   = StPre;
                    pre_cnt_d = PRE_W'(1);
                    cnt_d     = '0;
                end
            end

            StPre: begin
                if (stuck || (elapsed > PRE_HI) || (rise && (elapsed < PRE_LO))) begin
                    error_d = 1'b1;
                end else if (rise) begin
                    cnt_d     = '0;
                    pre_cnt_d = pre_cnt_q + PRE_W'(1);
                    if (pre_cnt_q + PRE_W'(1) == PRE_LAST) begin
                        state_d   = StSym;
                        sym_idx_d = '0;
                        // Last preamble pulse sits in the highest position.
                        v_prev_d  = '1;
                    end
                end
            end

            StSym: begin
                if (stuck || (elapsed > sym_top) || (rise && !sym_hit)) begin
                    error_d = 1'b1;
                end else if (rise) begin
                    cnt_d     = '0;
                    shift_d   = shift_next;
                    v_prev_d  = sym_w;
                    sym_idx_d = sym_idx_q + SYM_W'(1);
                    if (sym_idx_q + SYM_W'(1) == SYM_LAST) begin
                        state_d = StIdle;
                        if (!avail_q || read) begin
                            data_d  = shift_next;
                            avail_d = 1'b1;
                        end else begin
                            // Overrun: buffer still full, new frame is dropped.
                            error_d = 1'b1;
                        end
                    end
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase

        // Any fault abandons the partial frame; the offending rise is consumed.
        if (error_d) begin
            state_d   = StIdle;
            pre_cnt_d = '0;
            sym_idx_d = '0;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            pulse_q      <= 1'b0;
            pulse_prev_q <= 1'b0;
            hi_cnt_q     <= '0;
            cnt_q        <= '0;
            pre_cnt_q    <= '0;
            sym_idx_q    <= '0;
            v_prev_q     <= '0;
            shift_q      <= '0;
            data_q       <= '0;
            avail_q      <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            pulse_q      <= pulse;
            pulse_prev_q <= pulse_q;
            hi_cnt_q     <= hi_cnt_d;
            cnt_q        <= cnt_d;
            pre_cnt_q    <= pre_cnt_d;
            sym_idx_q    <= sym_idx_d;
            v_prev_q     <= v_prev_d;
            shift_q      <= shift_d;
            data_q       <= data_d;
            avail_q      <= avail_d;
            error_q      <= error_d;
        end
    end

    assign data  = data_q;
    assign avail = avail_q;
    assign error = error_q;

endmodule

// File: tb/tb_ppm_frame_receiver.sv
// Directed bench for ppm_frame_receiver with a load scoreboard and an error monitor.
module tb_ppm_frame_receiver;

    localparam int unsigned L_P     = 20;
    localparam int unsigned PULSE_P = 10;
    localparam int unsigned DELTA_P = 4;
    localparam int unsigned PRE_P   = 4;
    localparam int unsigned NMOD_P  = 2;
    localparam int unsigned NPKT_P  = 8;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       pulse = 1'b0;
    logic       read  = 1'b0;
    logic [7:0] data;
    logic       avail;
    logic       error;

    ppm_frame_receiver #(
        .PULSE_CT (PULSE_P),
        .N_MOD    (NMOD_P),
        .L        (L_P),
        .N_PKT    (NPKT_P),
        .PRE_CT   (PRE_P),
        .DELTA    (DELTA_P)
    ) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .pulse (pulse),
        .read  (read),
        .data  (data),
        .avail (avail),
        .error (error)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] val;
        int         cyc;
    } exp_t;

    exp_t       sb[$];
    int         rise_t[$];
    int         rise_h[$];
    int         n_checks     = 0;
    int         n_fail       = 0;
    int         cyc          = 0;
    int         err_seen     = 0;
    int         last_err_cyc = -1;
    logic       err_prev     = 1'b0;
    logic       avail_prev   = 1'b0;
    logic [7:0] data_prev    = 8'h00;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic read_once();
        read = 1'b1;
        tick();
        read = 1'b0;
    endtask

    // Encode a frame into rise times; optional alternating +/-4 jitter, one shifted rise,
    // and truncation to the first n_rises rises.
    task automatic build_frame(input logic [7:0] val, input int n_rises, input int shift_idx,
                               input int shift_amt, input bit alt);
        int t;
        int vp;
        int w;
        rise_t.delete();
        rise_h.delete();
        for (int i = 0; i < int'(PRE_P); i++) rise_t.push_back(i * int'(L_P));
        t  = (int'(PRE_P) - 1) * int'(L_P);
        vp = 3;
        for (int s = 0; s < 4; s++) begin
            w  = (int'(val) >> (6 - 2 * s)) & 3;
            t  = t + (4 - vp + w) * int'(L_P);
            vp = w;
            rise_t.push_back(t);
        end
        for (int i = 0; i < rise_t.size(); i++) begin
            if (alt && (i % 2 == 1)) rise_t[i] = rise_t[i] + ((i % 4 == 1) ? 4 : -4);
            if (i == shift_idx) rise_t[i] = rise_t[i] + shift_amt;
            rise_h.push_back(int'(PULSE_P));
        end
        while (rise_t.size() > n_rises) begin
            void'(rise_t.pop_back());
            void'(rise_h.pop_back());
        end
    endtask

    function automatic int last_rise();
        return rise_t[rise_t.size() - 1];
    endfunction

    // Play the waveform in rise_t/rise_h; read is high only on step read_step.
    task automatic play(input int tail, input int read_step);
        int  len;
        logic p;
        len = 0;
        foreach (rise_t[k]) if (rise_t[k] + rise_h[k] > len) len = rise_t[k] + rise_h[k];
        for (int i = 0; i < len + tail; i++) begin
            p = 1'b0;
            foreach (rise_t[k]) if (i >= rise_t[k] && i < rise_t[k] + rise_h[k]) p = 1'b1;
            pulse = p;
            read  = (i == read_step);
            tick();
        end
        pulse = 1'b0;
        read  = 1'b0;
    endtask

    task automatic expect_load(input logic [7:0] val);
        exp_t e;
        e.val = val;
        e.cyc = cyc + last_rise() + 2;
        sb.push_back(e);
    endtask

    // Output monitor: pops the scoreboard on every buffer load, tracks error strobes.
    always @(negedge clk) begin
        exp_t e;
        if (error) begin
            err_seen++;
            last_err_cyc = cyc;
            check("err_one_cycle", err_prev, 0);
        end
        err_prev = error;
        if (avail && (!avail_prev || data != data_prev)) begin
            check("load_expected", sb.size() != 0, 1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("load_data", data, e.val);
                check("load_cycle", cyc, e.cyc);
            end
        end
        avail_prev = avail;
        data_prev  = data;
    end

    initial begin
        int e0;
        int base;

        // Reset values
        repeat (3) tick();
        check("rst_data", data, 0);
        check("rst_avail", avail, 0);
        check("rst_error", error, 0);
        rst_n = 1'b1;
        tick();
        read_once();
        check("read_idle_ignored", avail, 0);

        // Basic frame
        e0 = err_seen;
        build_frame(8'hB4, 8, -1, 0, 1'b0);
        expect_load(8'hB4);
        play(10, -1);
        check("basic_err", err_seen - e0, 0);
        check("basic_avail", avail, 1);
        check("basic_data", data, 8'hB4);
        read_once();
        check("read_drop", avail, 0);

        // Jitter at the tolerance limit
        e0 = err_seen;
        build_frame(8'hB4, 8, -1, 0, 1'b1);
        expect_load(8'hB4);
        play(10, -1);
        check("jitter_err", err_seen - e0, 0);
        check("jitter_data", data, 8'hB4);
        read_once();

        // One symbol rise just outside tolerance
        e0 = err_seen;
        build_frame(8'hB4, 5, 4, 5, 1'b0);
        base = cyc;
        play(20, -1);
        check("jit5_err_count", err_seen - e0, 1);
        check("jit5_err_cycle", last_err_cyc, base + 125 + 2);
        check("jit5_avail", avail, 0);

        // Preamble timeout then a good frame
        e0 = err_seen;
        rise_t.delete();
        rise_h.delete();
        rise_t.push_back(0);
        rise_h.push_back(int'(PULSE_P));
        base = cyc;
        play(40, -1);
        check("pre_to_err_count", err_seen - e0, 1);
        check("pre_to_err_cycle", last_err_cyc, base + int'(L_P + DELTA_P) + 1 + 2);
        e0 = err_seen;
        build_frame(8'h3C, 8, -1, 0, 1'b0);
        expect_load(8'h3C);
        play(10, -1);
        check("after_to_err", err_seen - e0, 0);
        check("after_to_data", data, 8'h3C);
        read_once();

        // Overrun
        e0 = err_seen;
        build_frame(8'hB4, 8, -1, 0, 1'b0);
        expect_load(8'hB4);
        play(10, -1);
        build_frame(8'h3C, 8, -1, 0, 1'b0);
        base = cyc;
        play(10, -1);
        check("ovr_err_count", err_seen - e0, 1);
        check("ovr_err_cycle", last_err_cyc, base + last_rise() + 2);
        check("ovr_data", data, 8'hB4);
        check("ovr_avail", avail, 1);
        read_once();
        check("ovr_read_drop", avail, 0);

        // Read in the completion cycle
        e0 = err_seen;
        build_frame(8'hB4, 8, -1, 0, 1'b0);
        expect_load(8'hB4);
        play(10, -1);
        build_frame(8'h3C, 8, -1, 0, 1'b0);
        expect_load(8'h3C);
        play(10, last_rise() + 1);
        check("roc_err", err_seen - e0, 0);
        check("roc_data", data, 8'h3C);
        check("roc_avail", avail, 1);

        // Reset after the third symbol
        build_frame(8'hB4, 7, -1, 0, 1'b0);
        play(10, -1);
        rst_n = 1'b0;
        #2;
        check("midrst_data", data, 0);
        check("midrst_avail", avail, 0);
        check("midrst_error", error, 0);
        tick();
        rst_n = 1'b1;
        tick();
        e0 = err_seen;
        build_frame(8'h5A, 8, -1, 0, 1'b0);
        expect_load(8'h5A);
        play(10, -1);
        check("postrst_err", err_seen - e0, 0);
        check("postrst_data", data, 8'h5A);
        read_once();

        // Stuck line in the preamble
        e0 = err_seen;
        rise_t.delete();
        rise_h.delete();
        rise_t.push_back(0);
        rise_h.push_back(int'(PULSE_P));
        rise_t.push_back(int'(L_P));
        rise_h.push_back(15);
        base = cyc;
        play(20, -1);
        check("stuck_err_count", err_seen - e0, 1);
        check("stuck_err_cycle", last_err_cyc, base + int'(L_P) + 15 + 1);
        check("stuck_avail", avail, 0);

        tick();
        check("sb_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
